usb_crypto_regs: RTL and testbench

Second-generation host register front end for the CW305 target FPGA. It provides:
- separately parametrised key, plaintext and ciphertext banks;
- a control/status page with a GO/BUSY/DONE handshake to the crypto core;
- edge-qualified single-shot writes and a fixed-latency registered read path;
- a busy-cycle counter.

It sits between the top-level USB pad logic (bidirectional data buffer kept at top level) and the crypto core.

---
 rtl/usb_crypto_regs.sv | 184 ++++++++++++++++++
 tb/tb_usb_crypto_regs.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_crypto_regs.sv
// usb_crypto_regs: host register front end for the CW305 crypto target.
// Ports: clk/reset; usb_addr/usb_din/usb_rdn/usb_wrn/usb_cen from the pads;
// usb_dout/usb_isout to the pad buffer; key/text_in/start to the core;
// text_out/core_done from the core; busy while an operation runs.
module usb_crypto_regs #(
  parameter int         REGION_WIDTH = 8,
  parameter int         KEY_BYTES    = 16,
  parameter int         TEXT_BYTES   = 16,
  parameter logic [7:0] BLOCK_ID     = 8'hC5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [REGION_WIDTH+1:0]   usb_addr,
  input  logic [7:0]                usb_din,
  output logic [7:0]                usb_dout,
  output logic                      usb_isout,
  input  logic                      usb_rdn,
  input  logic                      usb_wrn,
  input  logic                      usb_cen,
  output logic [KEY_BYTES*8-1:0]    key,
  output logic [TEXT_BYTES*8-1:0]   text_in,
  input  logic [TEXT_BYTES*8-1:0]   text_out,
  output logic                      start,
  input  logic                      core_done,
  output logic                      busy
);

  localparam int KW =
    (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam int TW =
    (TEXT_BYTES > 1) ? $clog2(TEXT_BYTES) : 1;

  localparam logic [REGION_WIDTH:0] KEY_LIM =
    (REGION_WIDTH+1)'(KEY_BYTES);
  localparam logic [REGION_WIDTH:0] TEXT_LIM =
    (REGION_WIDTH+1)'(TEXT_BYTES);

  localparam logic [REGION_WIDTH-1:0] OFF_ID   = '0;
  localparam logic [REGION_WIDTH-1:0] OFF_CTRL = REGION_WIDTH'(1);
  localparam logic [REGION_WIDTH-1:0] OFF_STAT = REGION_WIDTH'(2);
  localparam logic [REGION_WIDTH-1:0] OFF_SCR  = REGION_WIDTH'(3);
  localparam logic [REGION_WIDTH-1:0] OFF_CYC0 = REGION_WIDTH'(4);
  localparam logic [REGION_WIDTH-1:0] OFF_CYC1 = REGION_WIDTH'(5);
  localparam logic [REGION_WIDTH-1:0] OFF_CYC2 = REGION_WIDTH'(6);
  localparam logic [REGION_WIDTH-1:0] OFF_CYC3 = REGION_WIDTH'(7);

  logic [REGION_WIDTH+1:0] addr_q;
  logic [7:0]              din_q;
  logic                    rdn_q;
  logic                    wrn_q;
  logic                    cen_q;
  logic                    wrn_prev;

  logic [7:0]  key_mem [KEY_BYTES];
  logic [7:0]  txt_mem [TEXT_BYTES];
  logic [7:0]  ct_mem  [TEXT_BYTES];
  logic [7:0]  scratch;
  logic [31:0] cycles;
  logic        done;

  logic [1:0]              region;
  logic [REGION_WIDTH-1:0] off;
  logic                    key_hit;
  logic                    text_hit;
  logic                    wr_commit;
  logic                    ctrl_wr;
  logic                    go;
  logic                    done_evt;
  logic                    clr_done;
  logic [7:0]              rd_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q   <= '0;
      din_q    <= '0;
      rdn_q    <= 1'b1;
      wrn_q    <= 1'b1;
      cen_q    <= 1'b1;
      wrn_prev <= 1'b1;
    end else begin
      addr_q   <= usb_addr;
      din_q    <= usb_din;
      rdn_q    <= usb_rdn;
      wrn_q    <= usb_wrn;
      cen_q    <= usb_cen;
      wrn_prev <= wrn_q;
    end
  end

  assign region   = addr_q[REGION_WIDTH+1 -: 2];
  assign off      = addr_q[REGION_WIDTH-1:0];
  assign key_hit  = {1'b0, off} < KEY_LIM;
  assign text_hit = {1'b0, off} < TEXT_LIM;

  // Only the first low cycle of a held write strobe commits.
  assign wr_commit = ~wrn_q & ~cen_q & wrn_prev;
  assign ctrl_wr   = wr_commit & (region == 2'd0)
                   & (off == OFF_CTRL);
  assign go        = ctrl_wr & din_q[0] & ~busy;
  assign done_evt  = core_done & busy;
  assign clr_done  = ctrl_wr & din_q[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < KEY_BYTES; i++) key_mem[i] <= '0;
      for (int i = 0; i < TEXT_BYTES; i++) txt_mem[i] <= '0;
      scratch <= '0;
    end else begin
      if (wr_commit & ~busy & key_hit & (region == 2'd1))
        key_mem[off[KW-1:0]] <= din_q;
      if (wr_commit & ~busy & text_hit & (region == 2'd2))
        txt_mem[off[TW-1:0]] <= din_q;
      if (wr_commit & (region == 2'd0) & (off == OFF_SCR))
        scratch <= din_q;
    end
  end

  // GO is only taken while idle, so it can never collide with
  // done_evt; a GO that also sets bit1 still leaves done at 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      start  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      cycles <= '0;
      for (int i = 0; i < TEXT_BYTES; i++) ct_mem[i] <= '0;
    end else begin
      start <= go;
      if (go) begin
        busy   <= 1'b1;
        done   <= 1'b0;
        cycles <= '0;
      end else begin
        if (busy && cycles != 32'hFFFF_FFFF)
          cycles <= cycles + 32'd1;
        if (done_evt) begin
          busy <= 1'b0;
          done <= 1'b1;
          for (int i = 0; i < TEXT_BYTES; i++)
            ct_mem[i] <= text_out[i*8 +: 8];
        end else if (clr_done) begin
          done <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    unique case (region)
      2'd0: begin
        if (off == OFF_ID)   rd_data = BLOCK_ID;
        if (off == OFF_STAT) rd_data = {6'd0, done, busy};
        if (off == OFF_SCR)  rd_data = scratch;
        if (off == OFF_CYC0) rd_data = cycles[7:0];
        if (off == OFF_CYC1) rd_data = cycles[15:8];
        if (off == OFF_CYC2) rd_data = cycles[23:16];
        if (off == OFF_CYC3) rd_data = cycles[31:24];
      end
      2'd1: if (key_hit) rd_data = key_mem[off[KW-1:0]];
      2'd2: if (text_hit) rd_data = txt_mem[off[TW-1:0]];
      2'd3: if (text_hit) rd_data = ct_mem[off[TW-1:0]];
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      usb_dout  <= '0;
      usb_isout <= 1'b0;
    end else begin
      usb_isout <= ~rdn_q & ~cen_q;
      if (!rdn_q) usb_dout <= rd_data;
    end
  end

  for (genvar i = 0; i < KEY_BYTES; i++) begin : g_key
    assign key[i*8 +: 8] = key_mem[i];
  end

  for (genvar i = 0; i < TEXT_BYTES; i++) begin : g_txt
    assign text_in[i*8 +: 8] = txt_mem[i];
  end

endmodule

// File: tb/tb_usb_crypto_regs.sv
// tb_usb_crypto_regs: directed bench for usb_crypto_regs.
// Drives the USB strobes and a stub core, checks against constants.
module tb_usb_crypto_regs;

  logic         clk = 1'b0;
  logic         reset;
  logic [9:0]   usb_addr;
  logic [7:0]   usb_din;
  logic [7:0]   usb_dout;
  logic         usb_isout;
  logic         usb_rdn;
  logic         usb_wrn;
  logic         usb_cen;
  logic [127:0] key;
  logic [127:0] text_in;
  logic [127:0] text_out;
  logic         start;
  logic         core_done;
  logic         busy;

  int total = 0;
  int bad   = 0;
  int starts = 0;

  always #5 clk = ~clk;

  usb_crypto_regs dut (
    .clk       (clk),
    .reset     (reset),
    .usb_addr  (usb_addr),
    .usb_din   (usb_din),
    .usb_dout  (usb_dout),
    .usb_isout (usb_isout),
    .usb_rdn   (usb_rdn),
    .usb_wrn   (usb_wrn),
    .usb_cen   (usb_cen),
    .key       (key),
    .text_in   (text_in),
    .text_out  (text_out),
    .start     (start),
    .core_done (core_done),
    .busy      (busy)
  );

  always @(negedge clk) if (start === 1'b1) starts++;

  typedef struct {
    logic [9:0] addr;
    logic [7:0] exp;
  } rvec_t;

  typedef struct {
    logic [9:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } wvec_t;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [9:0] a, input logic [7:0] d);
    @(posedge clk);
    #1 usb_addr = a; usb_din = d; usb_cen = 0; usb_wrn = 0;
    @(posedge clk);
    @(posedge clk);
    #1 usb_wrn = 1; usb_cen = 1;
  endtask

  task automatic rd(input logic [9:0] a, output logic [7:0] d);
    @(posedge clk);
    #1 usb_addr = a; usb_rdn = 0; usb_cen = 0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    d = usb_dout;
    usb_rdn = 1; usb_cen = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: no finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin
    rvec_t t1 [3];
    wvec_t tw [4];
    rvec_t t3 [6];
    logic [7:0]   d;
    logic [127:0] ct;
    logic [127:0] ct2;
    int           s0;

    t1[0] = '{10'h000, 8'hC5};
    t1[1] = '{10'h002, 8'h00};
    t1[2] = '{10'h0FF, 8'h00};
    tw[0] = '{10'h003, 8'h5A, 8'h5A};
    tw[1] = '{10'h200, 8'h11, 8'h11};
    tw[2] = '{10'h20F, 8'h22, 8'h22};
    tw[3] = '{10'h300, 8'h99, 8'h00};
    t3[0] = '{10'h002, 8'h02};
    t3[1] = '{10'h004, 8'h0B};
    t3[2] = '{10'h005, 8'h00};
    t3[3] = '{10'h006, 8'h00};
    t3[4] = '{10'h007, 8'h00};
    t3[5] = '{10'h001, 8'h00};
    ct  = 128'h3925841d02dc09fbdc118597196a0b32;
    ct2 = 128'h00112233445566778899aabbccddeeff;

    reset = 1; usb_addr = 0; usb_din = 0;
    usb_rdn = 1; usb_wrn = 1; usb_cen = 1;
    text_out = 0; core_done = 0;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_dout", usb_dout, 8'h00);
    chk("rst_isout", usb_isout, 1'b0);
    chk("rst_key", key, 128'h0);
    chk("rst_text", text_in, 128'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_start", start, 1'b0);

    // read latency and output-enable timing
    @(posedge clk);
    #1 usb_addr = 10'h000; usb_rdn = 0; usb_cen = 0;
    @(negedge clk);
    @(negedge clk);
    chk("lat1_dout", usb_dout, 8'h00);
    chk("lat1_isout", usb_isout, 1'b0);
    @(negedge clk);
    chk("lat2_dout", usb_dout, 8'hC5);
    chk("lat2_isout", usb_isout, 1'b1);
    usb_rdn = 1; usb_cen = 1;
    @(negedge clk);
    chk("oe_hold", usb_isout, 1'b1);
    @(negedge clk);
    chk("oe_off", usb_isout, 1'b0);

    for (int i = 0; i < 3; i++) begin
      rd(t1[i].addr, d);
      chk($sformatf("map_rd%0d", i), d, t1[i].exp);
    end

    // key bank
    for (int i = 0; i < 16; i++) wr(10'(10'h100 + i), 8'(i));
    @(negedge clk);
    chk("key_fill", key, 128'h0F0E0D0C0B0A09080706050403020100);

    // held strobe: data changes mid-hold, only the first value lands
    @(posedge clk);
    #1 usb_addr = 10'h103; usb_din = 8'hAA;
    usb_cen = 0; usb_wrn = 0;
    @(posedge clk);
    @(posedge clk);
    #1 usb_din = 8'h55;
    repeat (3) @(posedge clk);
    #1 usb_wrn = 1; usb_cen = 1; usb_din = 0;
    @(negedge clk);
    chk("key_hold", key[31:24], 8'hAA);

    wr(10'h110, 8'h77);
    @(negedge clk);
    chk("key_oob_wr", key, 128'h0F0E0D0C0B0A090807060504AA020100);
    rd(10'h110, d);
    chk("key_oob_rd", d, 8'h00);

    for (int i = 0; i < 4; i++) begin
      wr(tw[i].addr, tw[i].wdata);
      rd(tw[i].addr, d);
      chk($sformatf("wrrd%0d", i), d, tw[i].exp);
    end
    wr(10'h210, 8'h33);
    @(negedge clk);
    chk("text_lo", text_in[7:0], 8'h11);
    chk("text_hi", text_in[127:120], 8'h22);

    // GO / DONE handshake, 11 busy cycles
    s0 = starts;
    wr(10'h001, 8'h01);
    @(negedge clk);
    chk("go_start", start, 1'b1);
    chk("go_busy", busy, 1'b1);
    repeat (10) @(posedge clk);
    #1 core_done = 1; text_out = ct;
    @(posedge clk);
    #1 core_done = 0; text_out = 0;
    @(negedge clk);
    chk("done_busy", busy, 1'b0);
    chk("go_pulses", starts - s0, 1);
    for (int i = 0; i < 6; i++) begin
      rd(t3[i].addr, d);
      chk($sformatf("stat_rd%0d", i), d, t3[i].exp);
    end
    for (int i = 0; i < 16; i++) begin
      rd(10'(10'h300 + i), d);
      chk($sformatf("ct_rd%0d", i), d, ct[i*8 +: 8]);
    end

    // lock, ignored GO, then GO colliding with core_done
    s0 = starts;
    wr(10'h001, 8'h01);
    wr(10'h100, 8'hFF);
    wr(10'h001, 8'h01);
    @(posedge clk);
    #1 usb_addr = 10'h001; usb_din = 8'h01;
    usb_cen = 0; usb_wrn = 0;
    @(posedge clk);
    #1 core_done = 1; text_out = ct2;
    @(posedge clk);
    #1 core_done = 0; usb_wrn = 1; usb_cen = 1;
    @(negedge clk);
    chk("lock_key", key[7:0], 8'h00);
    chk("sim_busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    chk("sim_pulses", starts - s0, 1);
    rd(10'h002, d);
    chk("sim_stat", d, 8'h02);
    rd(10'h004, d);
    chk("sim_cyc", d, 8'h09);
    rd(10'h300, d);
    chk("sim_ct", d, ct2[7:0]);

    // GO and clear together while idle
    s0 = starts;
    wr(10'h001, 8'h03);
    @(negedge clk);
    chk("go3_start", start, 1'b1);
    chk("go3_busy", busy, 1'b1);
    rd(10'h002, d);
    chk("go3_stat", d, 8'h01);
    chk("go3_pulses", starts - s0, 1);

    // reset while busy, then a stray core_done
    @(posedge clk);
    #1 reset = 1;
    @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("mr_busy", busy, 1'b0);
    chk("mr_key", key, 128'h0);
    chk("mr_text", text_in, 128'h0);
    chk("mr_start", start, 1'b0);
    repeat (2) @(posedge clk);
    #1 core_done = 1; text_out = ct;
    @(posedge clk);
    #1 core_done = 0; text_out = 0;
    rd(10'h002, d);
    chk("mr_stat", d, 8'h00);
    rd(10'h004, d);
    chk("mr_cyc", d, 8'h00);
    rd(10'h003, d);
    chk("mr_scr", d, 8'h00);
    rd(10'h300, d);
    chk("mr_ct", d, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
